// File: rtl/pll_reset_ce_gen_pkg.sv
// Shared types and default ratios for the PLL-lock reset sequencer and its clock enables.
package pll_reset_ce_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYCLES = 4096;
  localparam int DEF_PIX_DIV     = 2;
  localparam int DEF_CPU_DIV     = 4;
  localparam int DEF_SND_NUM     = 3;
  localparam int DEF_SND_DEN     = 20;
  localparam int DEF_ACC_W       = 16;

  // Event priority, highest first: reset, loss of synchronised lock, soft_rst.
  // soft_rst only has an effect in RUN.

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_reset_ce_gen_if.sv
// Lock/soft-reset inputs and reset/clock-enable outputs between the sequencer and the core.
interface pll_reset_ce_gen_if;
  logic pll_locked;
  logic soft_rst;
  logic core_reset;
  logic ce_pix;
  logic ce_cpu;
  logic ce_snd;
  logic running;

  modport master (
    input  pll_locked, soft_rst,
    output core_reset, ce_pix, ce_cpu, ce_snd, running
  );

  modport slave (
    output pll_locked, soft_rst,
    input  core_reset, ce_pix, ce_cpu, ce_snd, running
  );
endinterface

// File: rtl/pll_reset_ce_gen_ce_frac_div.sv
// Fractional clock enable: NUM pulses every DEN enabled cycles via a phase accumulator.
module ce_frac_div #(
  parameter int NUM = 3,
  parameter int DEN = 20,
  parameter int W   = 16
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic en,
  output logic ce
);

  logic [W-1:0] acc;
  logic [W-1:0] acc_n;

  assign acc_n = acc + W'(NUM);

  always_ff @(posedge clk_sys) begin
    if (reset || !en) begin
      acc <= '0;
      ce  <= 1'b0;
    end else if (acc_n >= W'(DEN)) begin
      acc <= acc_n - W'(DEN);
      ce  <= 1'b1;
    end else begin
      acc <= acc_n;
      ce  <= 1'b0;
    end
  end

endmodule

// File: rtl/pll_reset_ce_gen.sv
// Holds the core in reset until PLL lock has been stable for HOLD_CYCLES, then runs its clock enables.
module pll_reset_ce_gen
  import pll_reset_ce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int PIX_DIV     = DEF_PIX_DIV,
  parameter int CPU_DIV     = DEF_CPU_DIV,
  parameter int SND_NUM     = DEF_SND_NUM,
  parameter int SND_DEN     = DEF_SND_DEN,
  parameter int ACC_W       = DEF_ACC_W
) (
  input  logic               clk_sys,
  input  logic               reset,
  pll_reset_ce_gen_if.master bus
);

  localparam int HOLD_W = cnt_w(HOLD_CYCLES);
  localparam int PIX_W  = cnt_w(PIX_DIV);
  localparam int CPU_W  = cnt_w(CPU_DIV);

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   lock_s;
  state_e                 state, state_nx;
  logic [HOLD_W-1:0]      hold_cnt, hold_nx;
  logic [PIX_W-1:0]       pix_cnt;
  logic [CPU_W-1:0]       cpu_cnt;
  logic                   in_run;
  logic                   ce_snd_w;

  always_ff @(posedge clk_sys) begin
    if (reset) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], bus.pll_locked};
  end

  assign lock_s = sync_pipe[SYNC_STAGES-1];
  assign in_run = (state == RUN);

  always_comb begin
    state_nx = state;
    hold_nx  = '0;
    case (state)
      WAIT_LOCK: if (lock_s) state_nx = HOLD;
      HOLD: begin
        if (!lock_s)                                state_nx = WAIT_LOCK;
        else if (hold_cnt == HOLD_W'(HOLD_CYCLES-1)) state_nx = RUN;
        else                                        hold_nx  = hold_cnt + HOLD_W'(1);
      end
      RUN: begin
        if (!lock_s)           state_nx = WAIT_LOCK;
        else if (bus.soft_rst) state_nx = HOLD;
      end
      default: state_nx = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= WAIT_LOCK;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
    end
  end

  // Dividers restart from zero on every entry to RUN, so the first pulse phase is fixed.
  always_ff @(posedge clk_sys) begin
    if (reset || !in_run) begin
      pix_cnt <= '0;
      cpu_cnt <= '0;
    end else begin
      pix_cnt <= (pix_cnt == PIX_W'(PIX_DIV-1)) ? '0 : pix_cnt + PIX_W'(1);
      cpu_cnt <= (cpu_cnt == CPU_W'(CPU_DIV-1)) ? '0 : cpu_cnt + CPU_W'(1);
    end
  end

  // Reset, running and every CE share one register stage, so they all switch on the same edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bus.core_reset <= 1'b1;
      bus.running    <= 1'b0;
      bus.ce_pix     <= 1'b0;
      bus.ce_cpu     <= 1'b0;
    end else begin
      bus.core_reset <= !in_run;
      bus.running    <= in_run;
      bus.ce_pix     <= in_run && (pix_cnt == PIX_W'(PIX_DIV-1));
      bus.ce_cpu     <= in_run && (cpu_cnt == CPU_W'(CPU_DIV-1));
    end
  end

  ce_frac_div #(
    .NUM (SND_NUM),
    .DEN (SND_DEN),
    .W   (ACC_W)
  ) u_snd (
    .clk_sys (clk_sys),
    .reset   (reset),
    .en      (in_run),
    .ce      (ce_snd_w)
  );

  assign bus.ce_snd = ce_snd_w;

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
// Directed bench for pll_reset_ce_gen with a lock-window reference model checked every cycle.
module tb_pll_reset_ce_gen;

  localparam int S = 2, H = 16, PIX = 2, CPU = 4, NUM = 3, DEN = 20;

  logic clk_sys = 1'b0;
  logic reset;
  pll_reset_ce_gen_if bus();

  pll_reset_ce_gen #(
    .SYNC_STAGES(S), .HOLD_CYCLES(H), .PIX_DIV(PIX), .CPU_DIV(CPU),
    .SND_NUM(NUM), .SND_DEN(DEN), .ACC_W(16)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model. Outputs after edge t are high-running iff the last H+1 lock samples
  // visible through the S-deep synchroniser were all high since the last reset, and no
  // honoured soft reset is still holding the core. CEs follow from the RUN cycle index k.
  int t = 0;
  int streak [0:8191];
  int last_rst = -1;
  int soft_blk = -1;
  int k = -1;
  bit model_ok = 0;
  bit m_run, m_pix, m_cpu, m_snd;

  always @(posedge clk_sys) begin
    t++;
    if (reset) begin
      streak[t] = 0;
      last_rst  = t;
      model_ok  = 1;
    end else begin
      streak[t] = (bus.pll_locked === 1'b1) ? streak[t-1] + 1 : 0;
    end
    m_run = !reset && (t-S-1 > last_rst) && (streak[t-S-1] >= H+1) && (t > soft_blk);
    if (!reset && bus.soft_rst && m_run && streak[t-S] > 0) soft_blk = t + H;
    k = m_run ? k + 1 : -1;
    m_pix = m_run && (k % PIX == PIX-1);
    m_cpu = m_run && (k % CPU == CPU-1);
    m_snd = m_run && ((NUM*(k+1))/DEN != (NUM*k)/DEN);
  end

  always @(negedge clk_sys) begin
    if (model_ok) begin
      chk("core_reset", bus.core_reset, !m_run);
      chk("running",    bus.running,    m_run);
      chk("ce_pix",     bus.ce_pix,     m_pix);
      chk("ce_cpu",     bus.ce_cpu,     m_cpu);
      chk("ce_snd",     bus.ce_snd,     m_snd);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Counts further edges until core_reset reaches lvl; 200 marks a timeout.
  task automatic wait_level(input logic lvl, output int n);
    n = 0;
    while (bus.core_reset !== lvl && n < 200) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    int n, bad, first_pix, first_cpu, first_snd, last_snd, pix40, cpu40, snd_cnt, orphan, bad_gap;
    reset = 1'b1;
    bus.pll_locked = 1'b0;
    bus.soft_rst = 1'b0;
    step(5);
    reset = 1'b0;
    chk("reset_core_reset", bus.core_reset, 1);
    chk("reset_running", bus.running, 0);
    chk("reset_ces", {bus.ce_pix, bus.ce_cpu, bus.ce_snd}, 0);

    bad = 0;
    repeat (100) begin
      step(1);
      if (bus.core_reset !== 1'b1) bad++;
    end
    chk("unlocked_held", bad, 0);

    // Lock rises: release 19 edges after the first edge that samples it.
    bus.pll_locked = 1'b1;
    step(1);
    wait_level(1'b0, n);
    chk("release_latency", n, 19);
    chk("running_at_release", bus.running, 1);

    // 200 RUN cycles starting at index 0 (current cycle).
    first_pix = -1; first_cpu = -1; first_snd = -1; last_snd = -1;
    pix40 = 0; cpu40 = 0; snd_cnt = 0; orphan = 0; bad_gap = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.ce_pix && first_pix < 0) first_pix = i;
      if (bus.ce_cpu && first_cpu < 0) first_cpu = i;
      if (bus.ce_cpu && !bus.ce_pix) orphan++;
      if (i < 40 && bus.ce_pix) pix40++;
      if (i < 40 && bus.ce_cpu) cpu40++;
      if (bus.ce_snd) begin
        if (first_snd < 0) first_snd = i;
        if (last_snd >= 0 && (i - last_snd != 6) && (i - last_snd != 7)) bad_gap++;
        last_snd = i;
        snd_cnt++;
      end
      step(1);
    end
    chk("first_ce_pix", first_pix, 1);
    chk("first_ce_cpu", first_cpu, 3);
    chk("pix_in_40", pix40, 20);
    chk("cpu_in_40", cpu40, 10);
    chk("cpu_without_pix", orphan, 0);
    chk("snd_pulses_200", snd_cnt, 30);
    chk("first_ce_snd", first_snd, 6);
    chk("snd_gap_6_or_7", bad_gap, 0);

    // Soft reset: core_reset rises one edge after the request edge, releases H+1 edges after it.
    bus.soft_rst = 1'b1;
    step(1);
    bus.soft_rst = 1'b0;
    chk("soft_request_edge", bus.core_reset, 0);
    step(1);
    chk("soft_rise", bus.core_reset, 1);
    chk("soft_ces_off", {bus.ce_pix, bus.ce_cpu, bus.ce_snd}, 0);
    wait_level(1'b0, n);
    chk("soft_release_latency", n + 1, H + 1);

    // Lock loss in RUN.
    step(10);
    bus.pll_locked = 1'b0;
    step(1);
    wait_level(1'b1, n);
    chk("loss_latency", n, 3);
    chk("loss_ces_off", {bus.ce_pix, bus.ce_cpu, bus.ce_snd}, 0);
    step(10);

    // Glitch while HOLD counter is around 10, then full hold from lock return.
    bus.pll_locked = 1'b1;
    step(11);
    bus.pll_locked = 1'b0;
    step(3);
    bus.pll_locked = 1'b1;
    step(1);
    wait_level(1'b0, n);
    chk("glitch_release_latency", n, 19);

    // reset and soft_rst together: reset wins, full resync from WAIT_LOCK; soft_rst in HOLD ignored.
    step(5);
    reset = 1'b1;
    bus.soft_rst = 1'b1;
    step(1);
    reset = 1'b0;
    bus.soft_rst = 1'b0;
    chk("reset_wins_core_reset", bus.core_reset, 1);
    chk("reset_wins_running", bus.running, 0);
    n = 0;
    while (bus.core_reset !== 1'b0 && n < 200) begin
      bus.soft_rst = (n == 8);
      step(1);
      n++;
    end
    bus.soft_rst = 1'b0;
    chk("reset_wins_release", n, 20);

    step(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=%0t expected=finish", $time);
    $fatal(1);
  end

endmodule
